// File: rtl/alu_seq.sv
// Registered, parametrised ALU with multi-cycle N-bit shifts and start/busy/done handshake.
// Optional shift-add multiplier on MUL (1011) when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cin,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alu_func,
    output logic [WIDTH-1:0] alu_out,
    output logic             c,
    output logic             z,
    output logic             v,
    output logic             s,
    output logic             busy,
    output logic             done
);

    localparam int unsigned XW = WIDTH + 1;
`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CW = SW + 1;
`else
    localparam int unsigned CW = SW;
`endif

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL1 = 4'b0101;
    localparam logic [3:0] OP_SHR1 = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SHLN = 4'b1000;
    localparam logic [3:0] OP_SHRN = 4'b1001;
    localparam logic [3:0] OP_SARN = 4'b1010;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1011;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] out_n;
    logic             c_n, z_n, v_n, s_n, busy_n, done_n;
    logic [3:0]       op, op_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0]    cnt, cnt_n;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] hi, hi_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] mul_hi, mul_lo;
`endif

    logic [WIDTH:0]   sum_w, dif_w;
    logic [WIDTH-1:0] res_c;
    logic             cf_c, vf_c;
    logic [WIDTH-1:0] sh_step;
    logic             sh_out;
    logic             is_shift;

    // Single-cycle result; shift codes only land here with a zero count
    always_comb begin
        sum_w = {1'b0, alu_b} + {1'b0, alu_a} + XW'(cin);
        dif_w = {1'b0, alu_b} - {1'b0, alu_a} - XW'(cin);
        res_c = '0;
        cf_c  = 1'b0;
        vf_c  = 1'b0;
        case (alu_func)
            OP_ADD: begin
                res_c = sum_w[WIDTH-1:0];
                cf_c  = sum_w[WIDTH];
                vf_c  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_w[WIDTH-1] != alu_b[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = dif_w[WIDTH-1:0];
                cf_c  = dif_w[WIDTH];
                vf_c  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (dif_w[WIDTH-1] != alu_b[WIDTH-1]);
            end
            OP_AND:  res_c = alu_a & alu_b;
            OP_OR:   res_c = alu_a | alu_b;
            OP_XOR:  res_c = alu_a ^ alu_b;
            OP_SHL1: begin
                res_c = {alu_b[WIDTH-2:0], 1'b0};
                cf_c  = alu_b[WIDTH-1];
            end
            OP_SHR1: begin
                res_c = {1'b0, alu_b[WIDTH-1:1]};
                cf_c  = alu_b[0];
            end
            OP_NOT:  res_c = ~alu_b;
            OP_SHLN, OP_SHRN, OP_SARN: res_c = alu_b;
            default: res_c = '0;
        endcase
    end

    // One shift step on the latched operand
    always_comb begin
        sh_step = sh;
        sh_out  = 1'b0;
        case (op)
            OP_SHLN: begin
                sh_step = {sh[WIDTH-2:0], 1'b0};
                sh_out  = sh[WIDTH-1];
            end
            OP_SHRN: begin
                sh_step = {1'b0, sh[WIDTH-1:1]};
                sh_out  = sh[0];
            end
            OP_SARN: begin
                sh_step = {sh[WIDTH-1], sh[WIDTH-1:1]};
                sh_out  = sh[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add step: {hi,sh} holds partial product and remaining multiplier bits
    always_comb begin
        madd   = {1'b0, hi} + (sh[0] ? {1'b0, mcand} : '0);
        mul_hi = madd[WIDTH:1];
        mul_lo = {madd[0], sh[WIDTH-1:1]};
    end
`endif

    assign is_shift = (alu_func == OP_SHLN) || (alu_func == OP_SHRN) || (alu_func == OP_SARN);

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        out_n   = alu_out;
        c_n     = c;
        z_n     = z;
        v_n     = v;
        s_n     = s;
        busy_n  = busy;
        done_n  = 1'b0;
        op_n    = op;
        sh_n    = sh;
        cnt_n   = cnt;
`ifdef ALU_SEQ_MUL_EN
        hi_n    = hi;
        mcand_n = mcand;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_shift && (alu_a[SW-1:0] != '0)) begin
                        op_n    = alu_func;
                        sh_n    = alu_b;
                        cnt_n   = CW'(alu_a[SW-1:0]);
                        busy_n  = 1'b1;
                        state_n = EXEC;
`ifdef ALU_SEQ_MUL_EN
                    end else if (alu_func == OP_MUL) begin
                        op_n    = alu_func;
                        sh_n    = alu_b;
                        hi_n    = '0;
                        mcand_n = alu_a;
                        cnt_n   = CW'(WIDTH);
                        busy_n  = 1'b1;
                        state_n = EXEC;
`endif
                    end else begin
                        out_n  = res_c;
                        c_n    = cf_c;
                        v_n    = vf_c;
                        z_n    = (res_c == '0);
                        s_n    = res_c[WIDTH-1];
                        done_n = 1'b1;
                    end
                end
            end
            EXEC: begin
                cnt_n = cnt - CW'(1);
                sh_n  = sh_step;
`ifdef ALU_SEQ_MUL_EN
                if (op == OP_MUL) begin
                    sh_n = mul_lo;
                    hi_n = mul_hi;
                end
`endif
                if (cnt == CW'(1)) begin
                    out_n = sh_step;
                    c_n   = sh_out;
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        out_n = mul_lo;
                        c_n   = (mul_hi != '0);
                    end
`endif
                    v_n     = 1'b0;
                    z_n     = (out_n == '0);
                    s_n     = out_n[WIDTH-1];
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            alu_out <= '0;
            c       <= 1'b0;
            z       <= 1'b0;
            v       <= 1'b0;
            s       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            op      <= '0;
            sh      <= '0;
            cnt     <= '0;
`ifdef ALU_SEQ_MUL_EN
            hi      <= '0;
            mcand   <= '0;
`endif
        end else begin
            state   <= state_n;
            alu_out <= out_n;
            c       <= c_n;
            z       <= z_n;
            v       <= v_n;
            s       <= s_n;
            busy    <= busy_n;
            done    <= done_n;
            op      <= op_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
`ifdef ALU_SEQ_MUL_EN
            hi      <= hi_n;
            mcand   <= mcand_n;
`endif
        end
    end

endmodule
